// File: rtl/vending_pkg.sv
// Shared vending definitions: coin values, drink codes and prices, and the
// change dispenser state encoding.
package vending_pkg;

    localparam int COIN_1  = 1;
    localparam int COIN_5  = 5;
    localparam int COIN_10 = 10;

    localparam int DRINK_TEA    = 1;
    localparam int DRINK_COKE   = 2;
    localparam int DRINK_COFFEE = 3;
    localparam int DRINK_MILK   = 4;

    localparam int PRICE_TEA    = 10;
    localparam int PRICE_COKE   = 15;
    localparam int PRICE_COFFEE = 20;
    localparam int PRICE_MILK   = 25;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        EJECT  = 2'd2,
        FINISH = 2'd3
    } disp_state_t;

    // Price lookup by drink code; unknown codes cost nothing.
    function automatic int drink_price(input int code);
        case (code)
            DRINK_TEA:    return PRICE_TEA;
            DRINK_COKE:   return PRICE_COKE;
            DRINK_COFFEE: return PRICE_COFFEE;
            DRINK_MILK:   return PRICE_MILK;
            default:      return 0;
        endcase
    endfunction

endpackage

// File: rtl/coin_inventory.sv
// Three saturating per-denomination coin counters with increment (customer
// coin), decrement (hopper ejection) and bulk restock.
module coin_inventory
    import vending_pkg::*;
#(
    parameter int AMT_W = 6,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_en,
    input  logic [AMT_W-1:0] inc_coin,
    input  logic             dec_en,
    input  logic [AMT_W-1:0] dec_coin,
    input  logic             restock_en,
    input  logic [CNT_W-1:0] restock_1,
    input  logic [CNT_W-1:0] restock_5,
    input  logic [CNT_W-1:0] restock_10,
    output logic [CNT_W-1:0] count_1,
    output logic [CNT_W-1:0] count_5,
    output logic [CNT_W-1:0] count_10
);

    localparam logic [AMT_W-1:0] C1  = AMT_W'(COIN_1);
    localparam logic [AMT_W-1:0] C5  = AMT_W'(COIN_5);
    localparam logic [AMT_W-1:0] C10 = AMT_W'(COIN_10);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // A coincident increment and decrement cancel; increment saturates at the
    // top. Decrement never sees zero because selection requires a nonzero count.
    function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cnt,
                                                    input logic inc,
                                                    input logic dec);
        if (inc && !dec)
            return (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        else if (dec && !inc)
            return cnt - 1'b1;
        else
            return cnt;
    endfunction

    // Restock overwrites all counters and wins over a same-cycle coin insert.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_1  <= '0;
            count_5  <= '0;
            count_10 <= '0;
        end else if (restock_en) begin
            count_1  <= restock_1;
            count_5  <= restock_5;
            count_10 <= restock_10;
        end else begin
            count_1  <= next_count(count_1,  inc_en && (inc_coin == C1),  dec_en && (dec_coin == C1));
            count_5  <= next_count(count_5,  inc_en && (inc_coin == C5),  dec_en && (dec_coin == C5));
            count_10 <= next_count(count_10, inc_en && (inc_coin == C10), dec_en && (dec_coin == C10));
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Greedy change dispenser: pays a refund one coin at a time through a hopper
// handshake, largest available denomination first, and reports any shortfall.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int AMT_W = 6,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             refund_valid,
    input  logic [AMT_W-1:0] refund_amount,
    output logic             refund_ready,
    input  logic             coin_in_valid,
    input  logic [AMT_W-1:0] coin_in,
    input  logic             restock_en,
    input  logic [CNT_W-1:0] restock_1,
    input  logic [CNT_W-1:0] restock_5,
    input  logic [CNT_W-1:0] restock_10,
    output logic             eject_req,
    output logic [AMT_W-1:0] eject_coin,
    input  logic             eject_ack,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] short_amount,
    output logic             busy
);

    localparam logic [AMT_W-1:0] C1  = AMT_W'(COIN_1);
    localparam logic [AMT_W-1:0] C5  = AMT_W'(COIN_5);
    localparam logic [AMT_W-1:0] C10 = AMT_W'(COIN_10);

    disp_state_t      state;
    logic [AMT_W-1:0] remaining;
    logic [CNT_W-1:0] count_1;
    logic [CNT_W-1:0] count_5;
    logic [CNT_W-1:0] count_10;
    logic             sel_found;
    logic [AMT_W-1:0] sel_coin;
    logic             ack_take;

    // Only an acknowledged ejection consumes a coin; acks outside EJECT are noise.
    assign ack_take = (state == EJECT) && eject_ack;

    coin_inventory #(
        .AMT_W(AMT_W),
        .CNT_W(CNT_W)
    ) u_inv (
        .clk        (clk),
        .reset      (reset),
        .inc_en     (coin_in_valid),
        .inc_coin   (coin_in),
        .dec_en     (ack_take),
        .dec_coin   (eject_coin),
        .restock_en (restock_en && (state == IDLE)),
        .restock_1  (restock_1),
        .restock_5  (restock_5),
        .restock_10 (restock_10),
        .count_1    (count_1),
        .count_5    (count_5),
        .count_10   (count_10)
    );

    // Largest coin that fits in the remainder and is in stock; none when remainder is 0.
    always_comb begin
        sel_found = 1'b0;
        sel_coin  = '0;
        if (remaining >= C10 && count_10 != '0) begin
            sel_found = 1'b1;
            sel_coin  = C10;
        end else if (remaining >= C5 && count_5 != '0) begin
            sel_found = 1'b1;
            sel_coin  = C5;
        end else if (remaining >= C1 && count_1 != '0) begin
            sel_found = 1'b1;
            sel_coin  = C1;
        end
    end

    // Refund sequencer; every output is registered and set on the transition
    // into the state that owns it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            remaining    <= '0;
            eject_req    <= 1'b0;
            eject_coin   <= '0;
            done         <= 1'b0;
            short        <= 1'b0;
            short_amount <= '0;
            busy         <= 1'b0;
            refund_ready <= 1'b1;
        end else begin
            done         <= 1'b0;
            short        <= 1'b0;
            short_amount <= '0;
            case (state)
                IDLE: begin
                    if (refund_valid) begin
                        remaining    <= refund_amount;
                        state        <= SELECT;
                        busy         <= 1'b1;
                        refund_ready <= 1'b0;
                    end
                end
                SELECT: begin
                    if (sel_found) begin
                        eject_coin <= sel_coin;
                        eject_req  <= 1'b1;
                        state      <= EJECT;
                    end else begin
                        done         <= 1'b1;
                        short        <= (remaining != '0);
                        short_amount <= remaining;
                        state        <= FINISH;
                    end
                end
                EJECT: begin
                    if (eject_ack) begin
                        eject_req <= 1'b0;
                        remaining <= remaining - eject_coin;
                        state     <= SELECT;
                    end
                end
                FINISH: begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    refund_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter AMT_W, default 6: width of all money amounts and coin values (dollars).
REQ-002 SHALL have parameter CNT_W, default 4: width of each per-denomination coin inventory counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 refund_valid  input  1  a refund request is presented.
REQ-006 refund_amount  input  AMT_W  change to pay out; sampled on acceptance.
REQ-007 refund_ready  output  1  high only in IDLE; acceptance = refund_valid && refund_ready.
REQ-008 coin_in_valid  input  1  the VendingMachine accepted a customer coin this cycle.
REQ-009 coin_in  input  AMT_W  value of that coin (1, 5 or 10); other values ignored.
REQ-010 restock_en  input  1  overwrite inventory with restock_1/5/10.
REQ-011 restock_1, restock_5, restock_10  input  CNT_W each  new inventory counts.
REQ-012 eject_req  output  1  request to hopper to eject one coin.
REQ-013 eject_coin  output  AMT_W  coin value to eject; stable while eject_req is high.
REQ-014 eject_ack  input  1  hopper ejected the requested coin; ignored when eject_req is low.
REQ-015 done  output  1  one-cycle pulse when a refund completes.
REQ-016 short  output  1  valid with done; 1 = exact change not paid.
REQ-017 short_amount  output  AMT_W  unpaid remainder; valid with done, 0 when short = 0.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 FSM states SHALL be IDLE, SELECT, EJECT, FINISH.
REQ-020 IDLE: on acceptance, SHALL latch refund_amount into remaining and go to SELECT.
REQ-021 SELECT (one cycle): SHALL pick the largest d in {10,5,1} with d <= remaining and count_d > 0, register it as eject_coin and go to EJECT; if remaining = 0 or no such d, go to FINISH.
REQ-022 EJECT: eject_req SHALL be high and eject_coin held until eject_ack; on ack, remaining -= eject_coin, count_d -= 1, go to SELECT.
REQ-023 FINISH (one cycle): done = 1, short = (remaining != 0), short_amount = remaining; then IDLE.
REQ-024 refund_amount = 0 SHALL produce done in the 3rd cycle after acceptance (SELECT, FINISH) with no eject_req.
REQ-025 Greedy fallback: with count_10 = 0, a refund of 10 SHALL be paid as 5+5, or 5+1x5 etc. as inventory allows.
REQ-026 coin_in_valid with a legal coin SHALL increment that counter, saturating at 2^CNT_W-1, in any state.
REQ-027 Simultaneous increment (coin_in) and decrement (eject ack) of the same counter SHALL leave it unchanged.
REQ-028 restock_en SHALL take effect only in IDLE; ignored in other states; restock_en has priority over coin_in_valid in the same cycle.
REQ-029 Counters SHALL never wrap below 0 (guaranteed by REQ-021 selection).
REQ-030 refund_valid outside IDLE SHALL be ignored (refund_ready = 0).

Reset
REQ-031 Reset SHALL force state IDLE, remaining = 0, all inventory counters = 0.
REQ-032 Reset values: eject_req 0, eject_coin 0, done 0, short 0, short_amount 0, busy 0, refund_ready 1 after release.
REQ-033 Reset mid-EJECT SHALL drop eject_req immediately (asynchronous); the pending refund is abandoned with no done.

Structure
REQ-034 Shared package vending_pkg SHALL hold COIN_1/COIN_5/COIN_10 values, drink codes (1 tea, 2 coke, 3 coffee, 4 milk), drink prices (10/15/20/25) and the dispenser state enum.
REQ-035 One sub-module coin_inventory SHALL hold the three saturating counters with inc/dec/restock ports.

Verification
REQ-036 Restock 2/2/5 (10/5/1), refund 26 -> ejects 10,10,5,1 in order, done, short 0, counts 0/1/4.
REQ-037 Restock 0/1/2, refund 10 -> ejects 5,1,1, done, short 1, short_amount 3, counts all 0.
REQ-038 Refund 0 -> no eject_req, done pulse 3 cycles after acceptance, short 0.
REQ-039 count_5 = 15, eject_ack for a 5 coincident with coin_in 5 -> count_5 stays 15; coin_in 5 at 15 alone -> stays 15.
REQ-040 Hold eject_ack low 4 cycles in EJECT -> eject_req/eject_coin stable; assert reset -> eject_req 0 same cycle, state IDLE, no done.
REQ-041 restock_en while busy -> inventory unchanged; refund_valid while busy -> not accepted.
